host_frame_tx: RTL and testbench
================================

HOST_FRAME_TX -- requirements
Module: host_frame_tx

Interface
REQ-001 SHALL have parameter BYTE_GAP, default 0: number of idle cycles inserted between consecutive bytes of one frame (0..255).
REQ-002 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1: command request.
REQ-005 SHALL have port cmd_i, input, 2: command code; 0 = LOAD_NONCE, 1 = ENABLE, 2 = DISABLE, 3 = RESET_BEST.
REQ-006 SHALL have port nonce_i, input, 256: nonce payload for LOAD_NONCE.
REQ-007 SHALL have port cmd_ready_o, output, 1: block idle and able to accept a command.
REQ-008 SHALL have port tx_busy_i, input, 1: downstream UART busy.
REQ-009 SHALL have port tx_new_o, output, 1: one-cycle byte strobe to the UART.
REQ-010 SHALL have port tx_data_o, output, 8: byte qualified by tx_new_o.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse after the last byte of a frame is handed off.

Function
REQ-012 SHALL accept a command only when cmd_valid_i and cmd_ready_o are both 1; on acceptance, latch cmd_i and nonce_i and deassert cmd_ready_o on the next cycle.
REQ-013 SHALL emit header bytes 0x4E (LOAD_NONCE), 0x45 (ENABLE), 0x44 (DISABLE), 0x52 (RESET_BEST).
REQ-014 SHALL, for LOAD_NONCE, follow the header with 32 payload bytes, least significant byte first (nonce[7:0] first, nonce[255:248] last); other commands SHALL be header-only.
REQ-015 SHALL use states IDLE, LOAD, WAIT, GAP, DONE: IDLE->LOAD on accept; LOAD->WAIT after the strobe; WAIT->GAP when tx_busy_i=0, frame not complete, and BYTE_GAP>0; WAIT->LOAD when tx_busy_i=0, frame not complete, and BYTE_GAP=0; WAIT->DONE when tx_busy_i=0 and frame complete; GAP->LOAD after BYTE_GAP cycles; DONE->IDLE unconditionally.
REQ-016 SHALL assert tx_new_o for exactly one cycle in LOAD, and only when tx_busy_i=0; if tx_busy_i=1, LOAD SHALL hold without strobing.
REQ-017 SHALL ignore tx_busy_i in the first WAIT cycle after a strobe, covering the UART's one-cycle busy latency.
REQ-018 SHALL hold tx_data_o stable from the strobe cycle until the next strobe.
REQ-019 SHALL use a 6-bit byte index that counts 0..32 (0..33 with checksum) and never wraps within a frame.
REQ-020 SHALL pulse done_o for one cycle in DONE, and SHALL reassert cmd_ready_o on the following cycle.
REQ-021 SHALL ignore cmd_valid_i while cmd_ready_o=0; changes to nonce_i mid-frame SHALL NOT alter the bytes sent.
REQ-022 SHALL make the minimum spacing between strobes 2+BYTE_GAP cycles when tx_busy_i stays 0.

Reset
REQ-023 SHALL, when rst_i=0 at a clock edge, enter IDLE and force cmd_ready_o=1, tx_new_o=0, tx_data_o=0x00, done_o=0, byte index=0, checksum=0.
REQ-024 SHALL abort any frame in progress at reset mid-frame, with no further strobes and no done_o pulse.
REQ-025 SHALL, if cmd_valid_i=1 during reset, not accept the command until the first cycle after rst_i returns to 1.

Configuration
REQ-026 SHALL, when HOST_FRAME_CHECKSUM_EN is defined, append one trailing byte to every frame, equal to the XOR of the header and all payload bytes, before done_o.
REQ-027 SHALL, when HOST_FRAME_CHECKSUM_EN is undefined, send no trailing byte and compile no checksum register.

Verification
REQ-028 SHALL cover ENABLE with tx_busy_i=0: exactly one strobe with 0x45, then done_o one cycle after the WAIT release, then cmd_ready_o=1.
REQ-029 SHALL cover LOAD_NONCE with nonce=0x1F1E..0100 (byte k = k): header 0x4E, then bytes 0x00..0x1F in order, 33 strobes total; with HOST_FRAME_CHECKSUM_EN, a 34th byte 0x4E^0x00^...^0x1F = 0x4E.
REQ-030 SHALL cover tx_busy_i held 1 for 10 cycles after each strobe: no strobe while busy, bytes unchanged, ordering preserved.
REQ-031 SHALL cover BYTE_GAP=3 with tx_busy_i=0: strobes exactly 5 cycles apart.
REQ-032 SHALL cover rst_i=0 after the 10th payload byte: outputs at reset values the next cycle, no done_o, and a fresh DISABLE afterwards sends only 0x44.
REQ-033 SHALL cover cmd_valid_i and nonce_i changed mid-frame: both ignored, and the original frame bytes are sent intact.

Source files
------------

// File: rtl/host_frame_tx_if.sv
// Command/byte-stream bundle between the host sequencer and host_frame_tx.
// slave = the framer itself; master = whoever issues commands and models the UART.
interface host_frame_tx_if;
  logic         cmd_valid_i;
  logic [1:0]   cmd_i;
  logic [255:0] nonce_i;
  logic         cmd_ready_o;
  logic         tx_busy_i;
  logic         tx_new_o;
  logic [7:0]   tx_data_o;
  logic         done_o;

  modport slave (
    input  cmd_valid_i, cmd_i, nonce_i, tx_busy_i,
    output cmd_ready_o, tx_new_o, tx_data_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_i, nonce_i, tx_busy_i,
    input  cmd_ready_o, tx_new_o, tx_data_o, done_o
  );
endinterface

// File: rtl/host_frame_tx.sv
// Turns host commands into UART byte frames: one header byte, plus a 32-byte nonce for LOAD_NONCE.
// Define HOST_FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame.
//
// state | meaning
// IDLE  | cmd_ready_o high, waiting for a command
// LOAD  | next byte selected; strobes it once the UART is not busy
// WAIT  | strobe cycle; UART busy not yet valid, decide next step
// GAP   | BYTE_GAP idle cycles between bytes
// DONE  | done_o pulse, back to IDLE
module host_frame_tx #(
  parameter int unsigned BYTE_GAP = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  host_frame_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, GAP, DONE} state_t;

  localparam logic [1:0] CMD_LOAD_NONCE = 2'd0;
  localparam logic [7:0] GAP_LOAD = (BYTE_GAP == 0) ? 8'd0 : 8'(BYTE_GAP - 1);
`ifdef HOST_FRAME_CHECKSUM_EN
  localparam logic [5:0] TRAILER = 6'd1;
`else
  localparam logic [5:0] TRAILER = 6'd0;
`endif

  state_t       state;
  logic [1:0]   cmd_q;
  logic [255:0] nonce_q;
  logic [5:0]   byte_idx;
  logic [7:0]   gap_cnt;
  logic         wait_first;
  logic [5:0]   last_idx;
  logic [7:0]   header;
  logic [7:0]   next_byte;
`ifdef HOST_FRAME_CHECKSUM_EN
  logic [7:0]   csum;
`endif

  // Payload bytes come from the low end of nonce_q, which shifts down after each one.
  always_comb begin
    case (cmd_q)
      2'd0:    header = 8'h4E;
      2'd1:    header = 8'h45;
      2'd2:    header = 8'h44;
      default: header = 8'h52;
    endcase
    last_idx  = ((cmd_q == CMD_LOAD_NONCE) ? 6'd32 : 6'd0) + TRAILER;
    next_byte = (byte_idx == 6'd0) ? header : nonce_q[7:0];
`ifdef HOST_FRAME_CHECKSUM_EN
    if (byte_idx == last_idx) next_byte = csum;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      cmd_q           <= 2'd0;
      nonce_q         <= '0;
      byte_idx        <= 6'd0;
      gap_cnt         <= 8'd0;
      wait_first      <= 1'b0;
      bus.cmd_ready_o <= 1'b1;
      bus.tx_new_o    <= 1'b0;
      bus.tx_data_o   <= 8'h00;
      bus.done_o      <= 1'b0;
`ifdef HOST_FRAME_CHECKSUM_EN
      csum            <= 8'h00;
`endif
    end else begin
      bus.tx_new_o <= 1'b0;
      bus.done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            cmd_q           <= bus.cmd_i;
            nonce_q         <= bus.nonce_i;
            byte_idx        <= 6'd0;
            bus.cmd_ready_o <= 1'b0;
            state           <= LOAD;
`ifdef HOST_FRAME_CHECKSUM_EN
            csum            <= 8'h00;
`endif
          end
        end
        LOAD: begin
          if (!bus.tx_busy_i) begin
            bus.tx_new_o  <= 1'b1;
            bus.tx_data_o <= next_byte;
            if (byte_idx != 6'd0) nonce_q <= {8'h00, nonce_q[255:8]};
            wait_first    <= 1'b1;
            state         <= WAIT;
`ifdef HOST_FRAME_CHECKSUM_EN
            csum          <= csum ^ next_byte;
`endif
          end
        end
        WAIT: begin
          wait_first <= 1'b0;
          // The UART only raises busy a cycle after seeing the strobe; LOAD catches it.
          if (wait_first || !bus.tx_busy_i) begin
            if (byte_idx == last_idx) begin
              bus.done_o <= 1'b1;
              state      <= DONE;
            end else begin
              byte_idx <= byte_idx + 6'd1;
              if (BYTE_GAP > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= LOAD;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        DONE: begin
          bus.cmd_ready_o <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_host_frame_tx.sv
// Directed-plus-random bench for host_frame_tx: expected frames are built from the command
// table and nonce bytes, a small UART model drives tx_busy_i, and a monitor collects strobes.
module tb_host_frame_tx;
  typedef logic [7:0] byte_q_t [$];

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  host_frame_tx_if ab ();
  host_frame_tx_if gb ();

  host_frame_tx #(.BYTE_GAP(0)) u_dut (.clk_i(clk_i), .rst_i(rst_i), .bus(ab));
  host_frame_tx #(.BYTE_GAP(3)) u_gap (.clk_i(clk_i), .rst_i(rst_i), .bus(gb));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b0;

  byte_q_t got_q, ggot_q;
  int strobe_t[$];
  int gstrobe_t[$];
  int done_n = 0, gdone_n = 0, done_t = 0;
  int busy_viol = 0, stab_viol = 0;
  int busy_len = 0, busy_cnt = 0;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk_i) begin
    cyc++;
    rst_at_edge = rst_i;
  end

  // Monitor plus UART model: busy rises right after a strobe and holds busy_len cycles.
  always @(negedge clk_i) begin
    if (ab.tx_new_o) begin
      got_q.push_back(ab.tx_data_o);
      strobe_t.push_back(cyc);
      if (ab.tx_busy_i) busy_viol++;
      last_data = ab.tx_data_o;
      busy_cnt  = busy_len;
    end else begin
      if (!rst_at_edge) last_data = 8'h00;
      if (ab.tx_data_o !== last_data) stab_viol++;
      if (busy_cnt > 0) busy_cnt--;
    end
    if (ab.done_o) begin
      done_n++;
      done_t = cyc;
    end
    ab.tx_busy_i = (busy_cnt > 0);
  end

  always @(negedge clk_i) begin
    if (gb.tx_new_o) begin
      ggot_q.push_back(gb.tx_data_o);
      gstrobe_t.push_back(cyc);
    end
    if (gb.done_o) gdone_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic byte_q_t exp_frame(input logic [1:0] c, input logic [255:0] n);
    byte_q_t q;
    logic [7:0] hdr_tab [4];
`ifdef HOST_FRAME_CHECKSUM_EN
    logic [7:0] x;
`endif
    hdr_tab = '{8'h4E, 8'h45, 8'h44, 8'h52};
    q.push_back(hdr_tab[c]);
    if (c == 2'd0)
      for (int k = 0; k < 32; k++) q.push_back(n[8*k +: 8]);
`ifdef HOST_FRAME_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`endif
    return q;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] n;
    for (int i = 0; i < 8; i++) n[32*i +: 32] = $urandom();
    return n;
  endfunction

  function automatic int count_bad_spacing(input int ts[$], input int d);
    int nb = 0;
    for (int i = 1; i < ts.size(); i++) if (ts[i] - ts[i-1] != d) nb++;
    return nb;
  endfunction

  task automatic chk_frame(input string tag, input byte_q_t got, input byte_q_t exp);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ab.cmd_ready_o !== 1'b1 && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(ab.cmd_ready_o), 64'd1);
  endtask

  task automatic start_cmd(input string tag, input logic [1:0] c, input logic [255:0] n);
    wait_ready(tag);
    got_q.delete();
    strobe_t.delete();
    ab.cmd_valid_i = 1'b1;
    ab.cmd_i       = c;
    ab.nonce_i     = n;
    @(posedge clk_i); #1;
    ab.cmd_valid_i = 1'b0;
    chk({tag, "_ready_drop"}, 64'(ab.cmd_ready_o), 64'd0);
  endtask

  task automatic finish_frame(input string tag, input int d0);
    int n = 0;
    while (done_n == d0 && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({tag, "_done_cnt"}, 64'(done_n), 64'(d0 + 1));
    chk({tag, "_ready_after"}, 64'(ab.cmd_ready_o), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] c, input logic [255:0] n);
    int d0;
    d0 = done_n;
    start_cmd(tag, c, n);
    finish_frame(tag, d0);
    chk_frame(tag, got_q, exp_frame(c, n));
  endtask

  initial begin
    logic [255:0] nz, na, nb;
    logic [1:0]   rc;
    int           d0, n;

    ab.cmd_valid_i = 1'b0; ab.cmd_i = 2'd0; ab.nonce_i = '0;
    gb.cmd_valid_i = 1'b0; gb.cmd_i = 2'd0; gb.nonce_i = '0; gb.tx_busy_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    chk("rst_ready", 64'(ab.cmd_ready_o), 64'd1);
    chk("rst_tx_new", 64'(ab.tx_new_o), 64'd0);
    chk("rst_tx_data", 64'(ab.tx_data_o), 64'h00);
    chk("rst_done", 64'(ab.done_o), 64'd0);

    // ENABLE, UART idle
    busy_len = 0;
    run_frame("enable", 2'd1, rand256());
    chk("enable_done_lat", 64'(done_t - strobe_t[$]), 64'd1);

    // LOAD_NONCE with byte k = k, back-to-back strobes
    for (int k = 0; k < 32; k++) nz[8*k +: 8] = 8'(k);
    run_frame("nonce_seq", 2'd0, nz);
    chk("spacing2", 64'(count_bad_spacing(strobe_t, 2)), 64'd0);

    // UART busy for 10 cycles after each strobe
    busy_len = 10;
    run_frame("busy10", 2'd0, rand256());
    chk("busy10_no_strobe_busy", 64'(busy_viol), 64'd0);
    chk("busy10_data_stable", 64'(stab_viol), 64'd0);

    // Random commands, nonces and busy lengths
    for (int i = 0; i < 6; i++) begin
      busy_len = $urandom_range(0, 4);
      rc = 2'($urandom_range(0, 3));
      run_frame($sformatf("rnd%0d", i), rc, rand256());
    end
    chk("rnd_no_strobe_busy", 64'(busy_viol), 64'd0);

    // Mid-frame command and nonce changes must not disturb the frame
    busy_len = 0;
    na = rand256();
    d0 = done_n;
    start_cmd("midchg", 2'd0, na);
    n = 0;
    while (got_q.size() < 5 && n < 500) begin @(posedge clk_i); #1; n++; end
    n = 0;
    while (got_q.size() < 25 && n < 500) begin
      ab.cmd_valid_i = 1'b1;
      ab.cmd_i       = 2'($urandom_range(1, 3));
      ab.nonce_i     = rand256();
      @(posedge clk_i); #1;
      n++;
    end
    ab.cmd_valid_i = 1'b0;
    finish_frame("midchg", d0);
    chk_frame("midchg", got_q, exp_frame(2'd0, na));

    // Reset after the 10th payload byte, with a DISABLE request held through reset
    nb = rand256();
    d0 = done_n;
    start_cmd("rstmid", 2'd0, nb);
    n = 0;
    while (got_q.size() < 11 && n < 500) begin @(posedge clk_i); #1; n++; end
    rst_i = 1'b0;
    ab.cmd_valid_i = 1'b1;
    ab.cmd_i = 2'd2;
    ab.nonce_i = rand256();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    chk("rstmid_ready", 64'(ab.cmd_ready_o), 64'd1);
    chk("rstmid_tx_new", 64'(ab.tx_new_o), 64'd0);
    chk("rstmid_tx_data", 64'(ab.tx_data_o), 64'h00);
    chk("rstmid_done", 64'(ab.done_o), 64'd0);
    @(posedge clk_i); #1;
    ab.cmd_valid_i = 1'b0;
    chk("rstmid_accept_after", 64'(ab.cmd_ready_o), 64'd0);
    chk("rstmid_abort_cnt", 64'(got_q.size()), 64'd11);
    chk("rstmid_no_done", 64'(done_n), 64'(d0));
    got_q.delete();
    strobe_t.delete();
    finish_frame("disable", d0);
    chk_frame("disable", got_q, exp_frame(2'd2, 256'd0));

    // BYTE_GAP = 3 instance: strobes exactly 5 cycles apart
    na = rand256();
    gb.cmd_valid_i = 1'b1;
    gb.cmd_i       = 2'd0;
    gb.nonce_i     = na;
    @(posedge clk_i); #1;
    gb.cmd_valid_i = 1'b0;
    n = 0;
    while (gdone_n == 0 && n < 3000) begin @(posedge clk_i); #1; n++; end
    chk("gap3_done", 64'(gdone_n), 64'd1);
    chk_frame("gap3", ggot_q, exp_frame(2'd0, na));
    chk("gap3_spacing5", 64'(count_bad_spacing(gstrobe_t, 5)), 64'd0);
    chk("gap3_first_spacing", 64'(gstrobe_t[1] - gstrobe_t[0]), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
